reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement queue feeding the register file's commit port. Allocates a nonzero
//  tag per dispatched instruction (driven to the register file as its dependency number),
//  captures execution results by tag, retires one completed head entry per cycle.
//  Exposes two tag-lookup ports so dispatch reads results not yet committed.
// PARAMETERS
//  TAG_W  3   tag width; tag 0 is reserved as "no dependency"
//  DEPTH  7   entries, must equal 2**TAG_W-1; valid tags are 1..DEPTH
//  XLEN   32  data width
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  flush      in   1      discard all in-flight entries (mispredict)
//  disp_valid in   1      dispatch request
//  disp_rd    in   5      destination register of dispatched instruction
//  disp_ready out  1      = !full; dispatch accepted iff disp_valid & disp_ready
//  alloc_tag  out  TAG_W  tag given to the current dispatch (= tail), combinational
//  wb_valid   in   1      result broadcast valid
//  wb_tag     in   TAG_W  tag of broadcast result
//  wb_value   in   XLEN   broadcast result
//  q1_tag     in   TAG_W  lookup tag (query1 from register file)
//  q1_ready   out  1      entry q1_tag holds a result
//  q1_value   out  XLEN   that result
//  q2_tag/q2_ready/q2_value   same as q1 for second operand
//  commit     out  1      registered pulse: write data_in to reg_num
//  reg_num    out  5      committed destination register
//  data_in    out  XLEN   committed value
//  num_in     out  TAG_W  committed tag (register file clears dependency if still equal)
//  empty      out  1      no busy entries
// BEHAVIOUR
//  - Reset/flush: all entries not busy; head=tail=1; count=0; commit=0, reg_num=0,
//    data_in=0, num_in=0; empty=1, disp_ready=1, alloc_tag=1. rst takes priority over flush;
//    flush same cycle as dispatch/writeback: flush wins, nothing allocated or written.
//  - Entry: busy, ready, rd, value. Pointers wrap DEPTH -> 1, never take value 0.
//  - Dispatch (accepted): entry[tail] <= {busy=1, ready=0, rd=disp_rd}; tail advances;
//    count+1. full = (count==DEPTH), from registered count only: commit in same cycle
//    does NOT free a slot for a dispatch while full.
//  - Writeback: if wb_valid, wb_tag!=0 and entry busy: ready<=1, value<=wb_value.
//    wb_tag 0 or non-busy entry: ignored, no state change.
//  - Retire: if entry[head] busy & ready: next cycle commit=(rd!=0), reg_num=rd,
//    data_in=value, num_in=head; entry freed, head advances, count-1. rd==0 retires
//    silently (commit=0). commit is 1-cycle pulse; other commit outputs hold last value.
//  - Latency: wb at cycle N to head -> ready visible N+1 -> commit pulse at N+2.
//  - Dispatch + retire same cycle (not full): both occur, count unchanged.
//  - Lookup: qX_ready=1, qX_value=wb_value if wb_valid & wb_tag==qX_tag (bypass);
//    else entry ready & busy -> stored value; tag 0 or not ready -> ready=0, value=0.
//  - Dispatch to an rd also in flight: allowed; no ordering check here.
// STRUCTURE
//  - Shared package/include: TAG_W, XLEN, NO_DEP=0, REG_W=5, rob entry struct/field
//    widths; register file uses the same constants.
//  - Sub-module rob_ptr_inc: combinational wrap-increment 1..DEPTH, used for head and tail.
//  - Entries as separate busy/ready flag vectors plus rd/value arrays; index 0 unused.
// TESTING
//  1 Reset: assert rst 2 cycles -> empty=1, disp_ready=1, alloc_tag=1, commit=0.
//  2 Dispatch rd=5,6 (tags 1,2); wb tag2=0xBEEF then tag1=0x1234 -> commits in order:
//    reg 5/0x1234/tag1, then reg 6/0xBEEF/tag2 on consecutive cycles.
//  3 Fill 7 entries -> disp_ready=0, 8th dispatch ignored; complete head -> commit tag1,
//    next dispatch gets alloc_tag=1 (wrap).
//  4 Lookup: wb tag3=0x55 with q1_tag=3 same cycle -> q1_ready=1, q1_value=0x55;
//    q2_tag=0 -> q2_ready=0.
//  5 Dispatch rd=0, wb it -> retires with commit=0; next entry rd=7 commits normally.
//  6 Flush with 4 busy entries and wb in same cycle -> empty=1 next cycle, no commit, alloc_tag=1.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB/register-file constants, tag/data types and the commit record
package reorder_buffer_pkg;
  localparam int TAG_W = 3;
  localparam int DEPTH = 2**TAG_W - 1;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [REG_W-1:0] reg_t;
  typedef logic [XLEN-1:0] data_t;
  localparam tag_t NO_DEP = '0;
  typedef struct packed {
    logic  commit;
    reg_t  rd;
    data_t value;
    tag_t  tag;
  } commit_t;
endpackage

// File: rtl/reorder_buffer_ptr_inc.sv
// rob_ptr_inc: wrap-increment of a ROB pointer over 1..DEPTH (tag 0 is never produced)
module rob_ptr_inc
  import reorder_buffer_pkg::*;
(
  input  tag_t ptr,
  output tag_t nxt
);
  assign nxt = (ptr == tag_t'(DEPTH)) ? tag_t'(1) : ptr + tag_t'(1);
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retire queue; dispatch alloc_tag/disp_ready, wb_* capture, q1/q2 lookup, registered commit/reg_num/data_in/num_in, empty
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [REG_W-1:0] disp_rd,
  output logic             disp_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [XLEN-1:0]  wb_value,
  input  logic [TAG_W-1:0] q1_tag,
  output logic             q1_ready,
  output logic [XLEN-1:0]  q1_value,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q2_ready,
  output logic [XLEN-1:0]  q2_value,
  output logic             commit,
  output logic [REG_W-1:0] reg_num,
  output logic [XLEN-1:0]  data_in,
  output logic [TAG_W-1:0] num_in,
  output logic             empty
);
  logic [DEPTH:0] busy_q, busy_d, ready_q, ready_d;
  reg_t rd_q [DEPTH+1];
  reg_t rd_d [DEPTH+1];
  data_t value_q [DEPTH+1];
  data_t value_d [DEPTH+1];
  tag_t head_q, head_d, tail_q, tail_d, count_q, count_d, head_nxt, tail_nxt;
  commit_t cm_q, cm_d;
  logic full, disp_fire, retire, q1_byp, q2_byp;
  rob_ptr_inc u_head_inc (.ptr(head_q), .nxt(head_nxt));
  rob_ptr_inc u_tail_inc (.ptr(tail_q), .nxt(tail_nxt));
  always_comb begin
    full = count_q == tag_t'(DEPTH);
    disp_fire = disp_valid & ~full;
    retire = busy_q[head_q] & ready_q[head_q];
    busy_d = busy_q;
    ready_d = ready_q;
    rd_d = rd_q;
    value_d = value_q;
    head_d = head_q;
    tail_d = tail_q;
    cm_d = cm_q;
    cm_d.commit = 1'b0;
    if (disp_fire) begin
      busy_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q] = disp_rd;
      tail_d = tail_nxt;
    end
    // uses busy_q, so a result aimed at the slot being allocated this cycle is dropped
    if (wb_valid && wb_tag != NO_DEP && busy_q[wb_tag]) begin
      ready_d[wb_tag] = 1'b1;
      value_d[wb_tag] = wb_value;
    end
    if (retire) begin
      busy_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d = head_nxt;
      cm_d = '{commit: rd_q[head_q] != '0, rd: rd_q[head_q], value: value_q[head_q], tag: head_q};
    end
    count_d = count_q + tag_t'(disp_fire) - tag_t'(retire);
    if (flush) begin
      busy_d = '0;
      ready_d = '0;
      head_d = tag_t'(1);
      tail_d = tag_t'(1);
      count_d = '0;
      cm_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      ready_q <= '0;
      rd_q <= '{default: '0};
      value_q <= '{default: '0};
      head_q <= tag_t'(1);
      tail_q <= tag_t'(1);
      count_q <= '0;
      cm_q <= '0;
    end else begin
      busy_q <= busy_d;
      ready_q <= ready_d;
      rd_q <= rd_d;
      value_q <= value_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      cm_q <= cm_d;
    end
  end
  always_comb begin
    q1_byp = wb_valid && wb_tag == q1_tag;
    q2_byp = wb_valid && wb_tag == q2_tag;
    q1_ready = q1_tag != NO_DEP && (q1_byp || (busy_q[q1_tag] && ready_q[q1_tag]));
    q2_ready = q2_tag != NO_DEP && (q2_byp || (busy_q[q2_tag] && ready_q[q2_tag]));
    q1_value = !q1_ready ? '0 : q1_byp ? wb_value : value_q[q1_tag];
    q2_value = !q2_ready ? '0 : q2_byp ? wb_value : value_q[q2_tag];
  end
  assign disp_ready = ~full;
  assign alloc_tag = tail_q;
  assign empty = count_q == '0;
  assign commit = cm_q.commit;
  assign reg_num = cm_q.rd;
  assign data_in = cm_q.value;
  assign num_in = cm_q.tag;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vector table, corner sequences and random traffic against a queue model
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, disp_valid, wb_valid;
  logic [4:0] disp_rd;
  logic [2:0] wb_tag, q1_tag, q2_tag, alloc_tag, num_in;
  logic [31:0] wb_value, q1_value, q2_value, data_in;
  logic disp_ready, q1_ready, q2_ready, commit, empty;
  logic [4:0] reg_num;
  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_rd(disp_rd),
    .disp_ready(disp_ready), .alloc_tag(alloc_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_value(wb_value), .q1_tag(q1_tag), .q1_ready(q1_ready), .q1_value(q1_value),
    .q2_tag(q2_tag), .q2_ready(q2_ready), .q2_value(q2_value), .commit(commit),
    .reg_num(reg_num), .data_in(data_in), .num_in(num_in), .empty(empty)
  );
  typedef struct {
    int tag;
    logic [4:0] rd;
    bit rdy;
    logic [31:0] val;
  } ent_t;
  ent_t mq[$];
  int mtail = 1;
  bit mvalid = 0;
  logic e_commit;
  logic [4:0] e_reg;
  logic [31:0] e_data;
  logic [2:0] e_num;
  int checks = 0;
  int failures = 0;
  typedef struct {
    bit dv;
    logic [4:0] rd;
    bit wv;
    logic [2:0] wt;
    logic [31:0] wval;
    bit x_empty;
    logic [2:0] x_alloc;
    bit x_com;
    logic [4:0] x_reg;
    logic [31:0] x_data;
    logic [2:0] x_num;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic exp_q(input logic [2:0] t, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    if (t != 0) begin
      if (wb_valid && wb_tag == t) begin
        r = 1'b1;
        v = wb_value;
      end else
        foreach (mq[i])
          if (mq[i].tag == int'(t) && mq[i].rdy) begin
            r = 1'b1;
            v = mq[i].val;
          end
    end
  endtask
  task automatic model_check();
    logic r;
    logic [31:0] v;
    chk("empty", empty, mq.size() == 0);
    chk("disp_ready", disp_ready, mq.size() < 7);
    chk("alloc_tag", alloc_tag, mtail);
    chk("commit", commit, e_commit);
    chk("reg_num", reg_num, e_reg);
    chk("data_in", data_in, e_data);
    chk("num_in", num_in, e_num);
    exp_q(q1_tag, r, v);
    chk("q1_ready", q1_ready, r);
    chk("q1_value", q1_value, v);
    exp_q(q2_tag, r, v);
    chk("q2_ready", q2_ready, r);
    chk("q2_value", q2_value, v);
  endtask
  task automatic drive(input bit r, input bit f, input bit dv, input logic [4:0] rd, input bit wv,
                       input logic [2:0] wt, input logic [31:0] wval, input logic [2:0] t1, input logic [2:0] t2);
    @(negedge clk);
    rst = r; flush = f; disp_valid = dv; disp_rd = rd;
    wb_valid = wv; wb_tag = wt; wb_value = wval; q1_tag = t1; q2_tag = t2;
    #1;
    if (mvalid) model_check();
  endtask
  task automatic tick();
    bit ret;
    ent_t h;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
      mtail = 1;
      e_commit = 0; e_reg = 0; e_data = 0; e_num = 0;
      if (rst) mvalid = 1;
    end else begin
      ret = mq.size() > 0 && mq[0].rdy;
      if (ret) h = mq[0];
      if (wb_valid && wb_tag != 0)
        foreach (mq[i])
          if (mq[i].tag == int'(wb_tag)) begin
            mq[i].rdy = 1;
            mq[i].val = wb_value;
          end
      if (disp_valid && mq.size() < 7) begin
        mq.push_back('{tag: mtail, rd: disp_rd, rdy: 0, val: 0});
        mtail = mtail % 7 + 1;
      end
      e_commit = 0;
      if (ret) begin
        void'(mq.pop_front());
        e_commit = h.rd != 0;
        e_reg = h.rd;
        e_data = h.val;
        e_num = 3'(h.tag);
      end
    end
  endtask
  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask
  task automatic disp(input logic [4:0] rd);
    drive(0, 0, 1, rd, 0, 0, 0, 0, 0);
    tick();
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0,          1, 1, 0, 0, 0,          0};
    tbl[1]  = '{1, 5, 0, 0, 0,          1, 1, 0, 0, 0,          0};
    tbl[2]  = '{1, 6, 0, 0, 0,          0, 2, 0, 0, 0,          0};
    tbl[3]  = '{0, 0, 1, 2, 32'hBEEF,   0, 3, 0, 0, 0,          0};
    tbl[4]  = '{0, 0, 1, 1, 32'h1234,   0, 3, 0, 0, 0,          0};
    tbl[5]  = '{0, 0, 0, 0, 0,          0, 3, 0, 0, 0,          0};
    tbl[6]  = '{0, 0, 0, 0, 0,          0, 3, 1, 5, 32'h1234,   1};
    tbl[7]  = '{0, 0, 0, 0, 0,          1, 3, 1, 6, 32'hBEEF,   2};
    tbl[8]  = '{0, 0, 0, 0, 0,          1, 3, 0, 6, 32'hBEEF,   2};
    tbl[9]  = '{1, 0, 0, 0, 0,          1, 3, 0, 6, 32'hBEEF,   2};
    tbl[10] = '{1, 7, 0, 0, 0,          0, 4, 0, 6, 32'hBEEF,   2};
    tbl[11] = '{0, 0, 1, 3, 32'hAA,     0, 5, 0, 6, 32'hBEEF,   2};
    tbl[12] = '{0, 0, 1, 4, 32'hBB,     0, 5, 0, 6, 32'hBEEF,   2};
    tbl[13] = '{0, 0, 0, 0, 0,          0, 5, 0, 0, 32'hAA,     3};
    tbl[14] = '{0, 0, 0, 0, 0,          1, 5, 1, 7, 32'hBB,     4};
    tbl[15] = '{0, 0, 0, 0, 0,          1, 5, 0, 7, 32'hBB,     4};
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    do_reset();
    foreach (tbl[i]) begin
      drive(0, 0, tbl[i].dv, tbl[i].rd, tbl[i].wv, tbl[i].wt, tbl[i].wval, 0, 0);
      chk($sformatf("tbl%0d.empty", i), empty, tbl[i].x_empty);
      chk($sformatf("tbl%0d.disp_ready", i), disp_ready, 1);
      chk($sformatf("tbl%0d.alloc_tag", i), alloc_tag, tbl[i].x_alloc);
      chk($sformatf("tbl%0d.commit", i), commit, tbl[i].x_com);
      chk($sformatf("tbl%0d.reg_num", i), reg_num, tbl[i].x_reg);
      chk($sformatf("tbl%0d.data_in", i), data_in, tbl[i].x_data);
      chk($sformatf("tbl%0d.num_in", i), num_in, tbl[i].x_num);
      tick();
    end
    do_reset();
    for (int i = 0; i < 7; i++) disp(5'(i + 11));
    drive(0, 0, 1, 20, 0, 0, 0, 0, 0);
    chk("full.disp_ready", disp_ready, 0);
    chk("full.alloc_tag", alloc_tag, 1);
    tick();
    drive(0, 0, 1, 21, 1, 1, 32'h111, 0, 0);
    tick();
    drive(0, 0, 1, 22, 0, 0, 0, 0, 0);
    chk("full_retire.disp_ready", disp_ready, 0);
    tick();
    drive(0, 0, 1, 23, 0, 0, 0, 0, 0);
    chk("wrap.commit", commit, 1);
    chk("wrap.num_in", num_in, 1);
    chk("wrap.reg_num", reg_num, 11);
    chk("wrap.data_in", data_in, 32'h111);
    chk("wrap.disp_ready", disp_ready, 1);
    chk("wrap.alloc_tag", alloc_tag, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("refill.disp_ready", disp_ready, 0);
    chk("refill.alloc_tag", alloc_tag, 2);
    tick();
    do_reset();
    for (int i = 1; i <= 3; i++) disp(5'(i));
    drive(0, 0, 0, 0, 1, 3, 32'h55, 3, 0);
    chk("byp.q1_ready", q1_ready, 1);
    chk("byp.q1_value", q1_value, 32'h55);
    chk("byp.q2_ready", q2_ready, 0);
    chk("byp.q2_value", q2_value, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 3, 1);
    chk("stored.q1_ready", q1_ready, 1);
    chk("stored.q1_value", q1_value, 32'h55);
    chk("notready.q2_ready", q2_ready, 0);
    tick();
    do_reset();
    for (int i = 1; i <= 4; i++) disp(5'(i + 8));
    drive(0, 0, 0, 0, 1, 1, 32'h77, 0, 0);
    tick();
    drive(0, 1, 1, 30, 1, 2, 32'h99, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 2, 1);
    chk("flush.empty", empty, 1);
    chk("flush.commit", commit, 0);
    chk("flush.alloc_tag", alloc_tag, 1);
    chk("flush.reg_num", reg_num, 0);
    chk("flush.q1_ready", q1_ready, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] wt;
      wt = 3'($urandom_range(0, 7));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) wt = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
            5'($urandom), 1'($urandom), wt, $urandom, 3'($urandom), 3'($urandom));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
